// File: rtl/measure_pkg.sv
// Shared state encoding and default window lengths for the measurement sequencer.
`timescale 1ns/1ps
package measure_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_AMP,
        ST_CLASSIFY,
        ST_FREQ,
        ST_MA,
        ST_REPORT
    } state_t;

    localparam int unsigned DEF_SETTLE_SAMPLES = 64;
    localparam int unsigned DEF_AMP_SAMPLES    = 128;
    localparam int unsigned DEF_GATE_SAMPLES   = 200;
    localparam int unsigned DEF_MA_SAMPLES     = 256;
    localparam int unsigned DEF_CNT_W          = 16;
    localparam int unsigned DEF_VPP_W          = 8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/edge_gate_counter.sv
// Rising-edge detector on the sample strobe with a saturating, clearable edge counter.
`timescale 1ns/1ps
module edge_gate_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_sample_en,
    input  logic             i_count_en,
    input  logic             i_sig,
    output logic [CNT_W-1:0] o_count_next
);

    logic             r_prev;
    logic [CNT_W-1:0] r_count;
    logic             w_rise;

    assign w_rise = i_count_en && i_sample_en && !r_prev && i_sig;

    // Exposes the post-clock count so the result can be latched on the same edge as the last strobe.
    always_comb begin
        o_count_next = r_count;
        if (i_clr) begin
            o_count_next = '0;
        end else if (w_rise && (r_count != '1)) begin
            o_count_next = r_count + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev  <= 1'b0;
            r_count <= '0;
        end else begin
            r_count <= o_count_next;
            if (i_load || i_sample_en) begin
                r_prev <= i_sig;
            end
        end
    end

endmodule

// File: rtl/measure_scheduler.sv
// Sequences settle/amplitude/classify/frequency/MA phases and presents one latched result set.
`timescale 1ns/1ps
module measure_scheduler
    import measure_pkg::*;
#(
    parameter int unsigned SETTLE_SAMPLES = DEF_SETTLE_SAMPLES,
    parameter int unsigned AMP_SAMPLES    = DEF_AMP_SAMPLES,
    parameter int unsigned GATE_SAMPLES   = DEF_GATE_SAMPLES,
    parameter int unsigned MA_SAMPLES     = DEF_MA_SAMPLES,
    parameter int unsigned CNT_W          = DEF_CNT_W,
    parameter int unsigned VPP_W          = DEF_VPP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic             start,
    input  logic             auto_run,
    input  logic             abort,
    input  logic             ma_measure_enable,
    input  logic             signal_rectified,
    input  logic             is_sine_wave,
    input  logic [VPP_W-1:0] vpp_in,
    output logic             stage_clr,
    output logic             amp_en,
    output logic             freq_gate,
    output logic             ma_en,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] res_edges,
    output logic             res_sine,
    output logic [VPP_W-1:0] res_vpp,
    output logic             res_ma_done
);

    localparam int unsigned MAX_WIN = max_u(max_u(SETTLE_SAMPLES, AMP_SAMPLES),
                                            max_u(GATE_SAMPLES, MA_SAMPLES));
    // Window counter is CNT_W wide, widened only if a window length would not fit.
    localparam int unsigned WIN_W = max_u(CNT_W, $clog2(MAX_WIN));

    localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_SAMPLES - 1);
    localparam logic [WIN_W-1:0] AMP_LAST    = WIN_W'(AMP_SAMPLES - 1);
    localparam logic [WIN_W-1:0] GATE_LAST   = WIN_W'(GATE_SAMPLES - 1);
    localparam logic [WIN_W-1:0] MA_LAST     = WIN_W'(MA_SAMPLES - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIN_W-1:0] r_win_cnt;
    logic             w_win_last;
    logic             w_win_done;
    logic             w_counting;
    logic             w_restart;
    logic             w_freq_entry;
    logic [CNT_W-1:0] w_edges_next;

    logic             r_stage_clr;
    logic             r_amp_en;
    logic             r_freq_gate;
    logic             r_ma_en;
    logic             r_busy;
    logic             r_result_valid;
    logic [CNT_W-1:0] r_res_edges;
    logic             r_res_sine;
    logic [VPP_W-1:0] r_res_vpp;
    logic             r_res_ma_done;

    assign w_counting = (r_state == ST_SETTLE) || (r_state == ST_AMP) ||
                        (r_state == ST_FREQ)   || (r_state == ST_MA);

    always_comb begin
        w_win_last = 1'b0;
        case (r_state)
            ST_SETTLE: w_win_last = (r_win_cnt == SETTLE_LAST);
            ST_AMP:    w_win_last = (r_win_cnt == AMP_LAST);
            ST_FREQ:   w_win_last = (r_win_cnt == GATE_LAST);
            ST_MA:     w_win_last = (r_win_cnt == MA_LAST);
            default:   w_win_last = 1'b0;
        endcase
    end

    assign w_win_done = sample_en && w_win_last;

    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     if (start) w_state_next = ST_SETTLE;
                ST_SETTLE:   if (w_win_done) w_state_next = ST_AMP;
                ST_AMP:      if (w_win_done) w_state_next = ST_CLASSIFY;
                ST_CLASSIFY: w_state_next = ST_FREQ;
                ST_FREQ:     if (w_win_done) w_state_next = (r_res_sine && ma_measure_enable) ? ST_MA : ST_REPORT;
                ST_MA:       if (w_win_done) w_state_next = ST_REPORT;
                ST_REPORT:   if (r_result_valid && result_ready) w_state_next = auto_run ? ST_SETTLE : ST_IDLE;
                default:     w_state_next = ST_IDLE;
            endcase
        end
    end

    assign w_restart    = (w_state_next == ST_SETTLE) && (r_state != ST_SETTLE);
    assign w_freq_entry = (w_state_next == ST_FREQ) && (r_state != ST_FREQ);

    edge_gate_counter #(
        .CNT_W (CNT_W)
    ) u_edge_gate_counter (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clr        (w_restart),
        .i_load       (w_freq_entry),
        .i_sample_en  (sample_en),
        .i_count_en   (r_state == ST_FREQ),
        .i_sig        (signal_rectified),
        .o_count_next (w_edges_next)
    );

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_win_cnt      <= '0;
            r_stage_clr    <= 1'b0;
            r_amp_en       <= 1'b0;
            r_freq_gate    <= 1'b0;
            r_ma_en        <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_res_edges    <= '0;
            r_res_sine     <= 1'b0;
            r_res_vpp      <= '0;
            r_res_ma_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state) begin
                r_win_cnt <= '0;
            end else if (w_counting && sample_en) begin
                r_win_cnt <= r_win_cnt + 1'b1;
            end
            r_stage_clr    <= w_restart;
            r_amp_en       <= (w_state_next == ST_AMP);
            r_freq_gate    <= (w_state_next == ST_FREQ);
            r_ma_en        <= (w_state_next == ST_MA);
            r_busy         <= (w_state_next != ST_IDLE);
            r_result_valid <= (w_state_next == ST_REPORT);
            if ((r_state == ST_CLASSIFY) && (w_state_next == ST_FREQ)) begin
                r_res_sine <= is_sine_wave;
                r_res_vpp  <= vpp_in;
            end
            if ((w_state_next == ST_REPORT) && (r_state != ST_REPORT)) begin
                r_res_edges   <= w_edges_next;
                r_res_ma_done <= (r_state == ST_MA);
            end
        end
    end

    assign stage_clr    = r_stage_clr;
    assign amp_en       = r_amp_en;
    assign freq_gate    = r_freq_gate;
    assign ma_en        = r_ma_en;
    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign res_edges    = r_res_edges;
    assign res_sine     = r_res_sine;
    assign res_vpp      = r_res_vpp;
    assign res_ma_done  = r_res_ma_done;

endmodule

// File: doc/measure_scheduler.md
# measure_scheduler

Sequencing controller for the sampled-signal measurement chain (DC removal / Vpp, waveform classification, frequency count, modulation-depth measurement). It runs one measurement cycle per request, paced by the divided sample strobe `sample_en`. It gates each downstream stage in turn, counts rectified-signal edges during a fixed gate window, and latches one coherent result set. The result set is presented with a valid/ready handshake to the display/UART side.

## Interface
Parameters:
- `SETTLE_SAMPLES`, 64: sample strobes discarded after start, so the front end settles.
- `AMP_SAMPLES`, 128: sample strobes in the amplitude window (DC/Vpp accumulation).
- `GATE_SAMPLES`, 200: sample strobes in the frequency gate (10 ms at 20 kHz).
- `MA_SAMPLES`, 256: sample strobes in the modulation-depth window.
- `CNT_W`, 16: width of the edge counter and of every window counter.
- `VPP_W`, 8: width of `vpp_in`.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: asynchronous active-low reset.
- `sample_en` in 1: one-`clk` sample strobe from the clock divider.
- `start` in 1: level request; sampled only in IDLE.
- `auto_run` in 1: after the result is accepted, go to SETTLE instead of IDLE.
- `abort` in 1: force IDLE from any state.
- `ma_measure_enable` in 1: permit the MA phase.
- `signal_rectified` in 1: comparator/rectifier output.
- `is_sine_wave` in 1: classifier decision.
- `vpp_in` in VPP_W: current Vpp from the amplitude stage.
- `stage_clr` out 1: one-`clk` clear pulse to the accumulators.
- `amp_en` out 1: amplitude stage enable.
- `freq_gate` out 1: frequency gate active.
- `ma_en` out 1: MA stage enable.
- `busy` out 1: high in every state except IDLE.
- `result_valid` out 1: result set held stable.
- `result_ready` in 1: consumer accepts the result.
- `res_edges` out CNT_W: rising edges counted in the gate.
- `res_sine` out 1: latched `is_sine_wave`.
- `res_vpp` out VPP_W: latched `vpp_in`.
- `res_ma_done` out 1: the MA phase ran in this cycle.

## Operation
- States: IDLE, SETTLE, AMP, CLASSIFY, FREQ, MA, REPORT. Encoding goes in the shared package.
- IDLE -> SETTLE when `start`=1. `stage_clr` pulses on the transition clock.
- SETTLE, AMP, FREQ and MA each count `sample_en` strobes with `win_cnt`. The state exits on the clock carrying the Nth strobe (N = that state's parameter), and `win_cnt` clears on exit.
- Output per state:
  - AMP: `amp_en`=1.
  - FREQ: `freq_gate`=1.
  - MA: `ma_en`=1.
  - All other states: each of these is 0.
- AMP -> CLASSIFY. CLASSIFY lasts exactly one `clk`: it latches `res_sine`<=`is_sine_wave` and `res_vpp`<=`vpp_in`, then goes to FREQ.
- FREQ edge detection:
  - On each `sample_en`, `prev`<=`signal_rectified`.
  - A rising edge is `prev`=0 and current=1, counted only inside FREQ.
  - `prev` is reloaded with the current input on entry to FREQ, so no edge is counted on the first strobe.
  - The edge count saturates at 2^CNT_W-1.
- FREQ exit:
  - If `res_sine`=1 and `ma_measure_enable`=1, go to MA.
  - Otherwise go to REPORT with `res_ma_done`=0.
- MA exit: go to REPORT with `res_ma_done`=1.
- REPORT: `res_edges` is latched on entry and `result_valid`=1. When `result_valid`&`result_ready` in the same `clk`, go to SETTLE if `auto_run`=1 (with a `stage_clr` pulse), else to IDLE.
- `abort`=1 in any state: IDLE next `clk`, `result_valid`<=0, result registers kept. `abort` takes priority over `start` and over the handshake.
- Reset values: state IDLE, all enables 0, `stage_clr` 0, `busy` 0, `result_valid` 0, `res_*` 0, counters 0.

## Timing
- All outputs are registered; none depend combinationally on inputs.
- Cycle latency from `start`, in sample strobes: SETTLE+AMP+GATE(+MA) strobes, plus 1 `clk` for CLASSIFY, plus 1 `clk` to assert `result_valid`.
- `result_valid` and every `res_*` stay constant from assertion until the handshake clock.
- `sample_en` during CLASSIFY or REPORT is ignored, not deferred.
- Reset mid-cycle: outputs take reset values immediately (asynchronously); there is no partial result.

## Structure
- Package `measure_pkg`: state enum, default window lengths, `CNT_W`.
- One sub-module, `edge_gate_counter`: the `prev` register, rising-edge detect, and saturating counter with clear/enable.

## Test plan
Bench parameters: SETTLE=4, AMP=8, GATE=200, MA=16, `sample_en` every 2500 `clk`.
- Square `signal_rectified` with 20-strobe period, `is_sine_wave`=1, `ma_measure_enable`=1, `vpp_in`=50, one `start` -> `res_edges`=10, `res_sine`=1, `res_vpp`=50, `res_ma_done`=1, and `result_valid` after 228 strobes + 2 clk.
- Same stimulus with `is_sine_wave`=0 -> `res_ma_done`=0, MA is skipped, and `ma_en` is never high.
- `result_ready` held low for 10000 clk -> `result_valid` and `res_*` stay stable; then `ready`=1 for one clk -> IDLE next clk, `busy`=0.
- `auto_run`=1 with constant-high input -> back-to-back cycles, a `stage_clr` pulse at each restart, `res_edges`=0 each cycle.
- `abort` pulsed mid-FREQ together with `start`=1 -> IDLE next clk, `result_valid`=0, no restart until a later `start`.
- CNT_W=4 with 40 edges in the gate -> `res_edges`=15 (saturated); `rst_n` asserted in AMP -> all outputs at reset values.
